// File: rtl/flipflop_bloque_pingpong_pkg.sv
// Shared types and helpers for the ping-pong register block.
package flipflop_pkg;

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} pp_state_t;

  // Width of the fill counter, wide enough to hold 0..m.
  function automatic int CNT_W(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/flipflop_bloque_pingpong_if.sv
// Write/load/flip bus of the ping-pong block; the producer drives through the
// master modport and the block sits on the slave modport.
interface flipflop_bloque_pingpong_if #(
  parameter int N = 16,
  parameter int M = 16
);
  logic         wr_valid;
  logic [N-1:0] wr_data;
  logic         wr_ready;
  logic         ld_en;
  logic [N-1:0] ld_data [M-1:0];
  logic         flip;
  logic [N-1:0] q [M-1:0];
  logic         active_sel;
  logic         shadow_full;
  logic         flip_done;
  logic         flip_err;

  modport master (
    output wr_valid, wr_data, ld_en, ld_data, flip,
    input  wr_ready, q, active_sel, shadow_full, flip_done, flip_err
  );

  modport slave (
    input  wr_valid, wr_data, ld_en, ld_data, flip,
    output wr_ready, q, active_sel, shadow_full, flip_done, flip_err
  );
endinterface

// File: rtl/flipflop_bloque_pingpong_registro_banco.sv
// One M x N register bank: per-lane write of a shared word, or a whole-bank
// load of M words. The bank load wins over lane writes.
module registro_banco #(
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] lane_we_i,
  input  logic [N-1:0] lane_data_i,
  input  logic         bank_we_i,
  input  logic [N-1:0] bank_data_i [M-1:0],
  output logic [N-1:0] q_o [M-1:0]
);

  logic [N-1:0] mem_q [M-1:0];

  // Lane storage: clear on reset, bulk load, else single-lane write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < M; i++) begin
      if (rst)               mem_q[i] <= '0;
      else if (bank_we_i)    mem_q[i] <= bank_data_i[i];
      else if (lane_we_i[i]) mem_q[i] <= lane_data_i;
    end
  end

  assign q_o = mem_q;

endmodule

// File: rtl/flipflop_bloque_pingpong.sv
// Ping-pong register block: the active bank drives q while the shadow bank is
// filled by stream writes or a bulk load; a flip swaps them only when full.
module flipflop_bloque_pingpong #(
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic clk,
  input  logic rst,
  flipflop_bloque_pingpong_if.slave bus
);
  import flipflop_pkg::*;

  localparam int CW = CNT_W(M);

  pp_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         act_q, act_d;
  logic         fd_q, fd_d;
  logic         fe_q, fe_d;

  logic         wr_rdy, wr_go, flip_ok, ld_go;
  logic [M-1:0] lane_we, we_a, we_b;
  logic         ld_a, ld_b;
  logic [N-1:0] qa [M-1:0];
  logic [N-1:0] qb [M-1:0];

  // A flip accepted in FULL wins over a same-cycle load so the freshly freed
  // shadow (the old active bank) is not overwritten behind the swap.
  assign wr_rdy  = (state_q == FILL) && !bus.ld_en;
  assign wr_go   = bus.wr_valid && wr_rdy;
  assign flip_ok = bus.flip && (state_q == FULL);
  assign ld_go   = bus.ld_en && !flip_ok;

  // One-hot lane select from the fill counter.
  always_comb begin
    lane_we = '0;
    for (int i = 0; i < M; i++)
      lane_we[i] = wr_go && (cnt_q == CW'(i));
  end

  // Writes are steered to whichever bank is not active.
  assign we_a = act_q ? lane_we : '0;
  assign we_b = act_q ? '0 : lane_we;
  assign ld_a = act_q && ld_go;
  assign ld_b = !act_q && ld_go;

  registro_banco #(.N(N), .M(M)) u_banco_a (
    .clk        (clk),
    .rst        (rst),
    .lane_we_i  (we_a),
    .lane_data_i(bus.wr_data),
    .bank_we_i  (ld_a),
    .bank_data_i(bus.ld_data),
    .q_o        (qa)
  );

  registro_banco #(.N(N), .M(M)) u_banco_b (
    .clk        (clk),
    .rst        (rst),
    .lane_we_i  (we_b),
    .lane_data_i(bus.wr_data),
    .bank_we_i  (ld_b),
    .bank_data_i(bus.ld_data),
    .q_o        (qb)
  );

  // Next state: flip > bulk load > stream write; a rejected flip in FILL
  // does not stop the write/load of the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    fd_d    = flip_ok;
    fe_d    = bus.flip && (state_q == FILL);
    if (flip_ok) begin
      state_d = FILL;
      cnt_d   = '0;
      act_d   = !act_q;
    end else if (bus.ld_en) begin
      state_d = FULL;
      cnt_d   = '0;
    end else if (wr_go) begin
      if (cnt_q == CW'(M - 1)) begin
        state_d = FULL;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Control registers, all cleared together so no partial swap survives reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      act_q   <= 1'b0;
      fd_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      fd_q    <= fd_d;
      fe_q    <= fe_d;
    end
  end

  // Output mux: only the active bank is ever visible.
  for (genvar g = 0; g < M; g++) begin : g_qmux
    assign bus.q[g] = act_q ? qb[g] : qa[g];
  end

  assign bus.wr_ready    = wr_rdy;
  assign bus.active_sel  = act_q;
  assign bus.shadow_full = (state_q == FULL);
  assign bus.flip_done   = fd_q;
  assign bus.flip_err    = fe_q;

endmodule

// File: tb/tb_flipflop_bloque_pingpong.sv
// Directed bench for the ping-pong block: the driver pushes hand-computed
// expected snapshots tagged with a cycle number, the monitor pops and compares.
module tb_flipflop_bloque_pingpong;
  localparam int N = 16;
  localparam int M = 16;

  typedef struct {
    int             cyc;
    string          nm;
    logic [M*N-1:0] q;
    logic           act, full, rdy, fd, fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   fd_seen = 0;
  int   fe_seen = 0;
  exp_t sb [$];
  exp_t mon_e;
  logic [M*N-1:0] exp_q;
  logic [M*N-1:0] qflat;

  always #5 clk = ~clk;

  flipflop_bloque_pingpong_if #(.N(N), .M(M)) bif ();

  flipflop_bloque_pingpong #(.N(N), .M(M)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif.slave)
  );

  always_comb begin
    qflat = '0;
    for (int i = 0; i < M; i++) qflat[i*N +: N] = bif.q[i];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: count pulses every cycle, check every expectation due now.
  always @(negedge clk) begin
    if (bif.flip_done === 1'b1) fd_seen <= fd_seen + 1;
    if (bif.flip_err === 1'b1)  fe_seen <= fe_seen + 1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      vectors = vectors + 1;
      if (mon_e.cyc < cyc) begin
        miscompares = miscompares + 1;
        $display("FAIL %s: checked at cycle %0d, wanted cycle %0d", mon_e.nm, cyc, mon_e.cyc);
      end else if (qflat !== mon_e.q || bif.active_sel !== mon_e.act ||
                   bif.shadow_full !== mon_e.full || bif.wr_ready !== mon_e.rdy ||
                   bif.flip_done !== mon_e.fd || bif.flip_err !== mon_e.fe) begin
        miscompares = miscompares + 1;
        $display("FAIL %s: got q=%h act=%b full=%b rdy=%b fd=%b fe=%b want q=%h act=%b full=%b rdy=%b fd=%b fe=%b",
                 mon_e.nm, qflat, bif.active_sel, bif.shadow_full, bif.wr_ready,
                 bif.flip_done, bif.flip_err, mon_e.q, mon_e.act, mon_e.full,
                 mon_e.rdy, mon_e.fd, mon_e.fe);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic a, input logic f,
                     input logic r, input logic d, input logic e);
    exp_t x;
    x.cyc = cyc; x.nm = nm; x.q = exp_q;
    x.act = a; x.full = f; x.rdy = r; x.fd = d; x.fe = e;
    sb.push_back(x);
  endtask

  task automatic wr(input logic [N-1:0] d);
    bif.wr_valid = 1'b1;
    bif.wr_data  = d;
    tick();
    bif.wr_valid = 1'b0;
  endtask

  task automatic do_flip();
    bif.flip = 1'b1;
    tick();
    bif.flip = 1'b0;
  endtask

  task automatic set_q_seq(input logic [N-1:0] base);
    for (int i = 0; i < M; i++) exp_q[i*N +: N] = base + N'(i);
  endtask

  task automatic set_ld(input logic [N-1:0] base);
    for (int i = 0; i < M; i++) bif.ld_data[i] = base + N'(i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required end of stimulus");
    $fatal(1);
  end

  initial begin
    bif.wr_valid = 1'b0; bif.wr_data = '0; bif.ld_en = 1'b0; bif.flip = 1'b0;
    set_ld('0);
    exp_q = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset", 0, 0, 1, 0, 0);

    // 16 stream writes 1..16 into bank B; q stays zero
    for (int i = 0; i < M; i++) begin
      wr(N'(i + 1));
      if (i == M - 2) chk("fill15", 0, 0, 1, 0, 0);
    end
    chk("fill16", 0, 1, 0, 0, 0);

    do_flip();
    set_q_seq(16'd1);
    chk("flip1", 1, 0, 1, 1, 0);
    tick();
    chk("flip1_pulse_end", 1, 0, 1, 0, 0);

    // 5 writes with a gap, rejected flip, then 11 more to reach FULL
    for (int i = 0; i < 5; i++) begin
      wr(16'h0100 + N'(i));
      if (i == 1) tick();
    end
    do_flip();
    chk("flip_err", 1, 0, 1, 0, 1);
    tick();
    chk("flip_err_end", 1, 0, 1, 0, 0);
    for (int i = 5; i < M; i++) wr(16'h0100 + N'(i));
    chk("fill_after_err", 1, 1, 0, 0, 0);
    do_flip();
    set_q_seq(16'h0100);
    chk("flip2", 0, 0, 1, 1, 0);

    // bulk load beats a same-cycle stream write, then flip right after
    for (int i = 0; i < 3; i++) wr(16'h0300 + N'(i));
    bif.ld_en = 1'b1; set_ld(16'hA000);
    bif.wr_valid = 1'b1; bif.wr_data = 16'hDEAD;
    chk("ld_blocks_wr", 0, 0, 0, 0, 0);
    tick();
    bif.ld_en = 1'b0; bif.wr_valid = 1'b0;
    chk("ld_full", 0, 1, 0, 0, 0);
    do_flip();
    set_q_seq(16'hA000);
    chk("flip_ld", 1, 0, 1, 1, 0);

    // rejected flip on the last-lane write still reaches FULL
    for (int i = 0; i < M - 1; i++) wr(16'h0200 + N'(i));
    bif.wr_valid = 1'b1; bif.wr_data = 16'h020F; bif.flip = 1'b1;
    tick();
    bif.wr_valid = 1'b0; bif.flip = 1'b0;
    chk("err_last_lane", 1, 1, 0, 0, 1);
    tick();
    chk("err_last_lane_end", 1, 1, 0, 0, 0);

    // flip and load together in FULL: swap happens, load ignored
    bif.flip = 1'b1; bif.ld_en = 1'b1; set_ld(16'h5000);
    tick();
    bif.flip = 1'b0; bif.ld_en = 1'b0;
    set_q_seq(16'h0200);
    chk("flip_and_ld", 0, 0, 1, 1, 0);

    // reset after 8 writes with flip high
    for (int i = 0; i < 8; i++) wr(16'h0700 + N'(i));
    rst = 1'b1; bif.flip = 1'b1;
    tick();
    rst = 1'b0; bif.flip = 1'b0;
    exp_q = '0;
    chk("rst_mid", 0, 0, 1, 0, 0);
    tick();
    chk("rst_mid_next", 0, 0, 1, 0, 0);
    for (int i = 0; i < M - 1; i++) wr(16'h0800 + N'(i));
    chk("post_rst_fill15", 0, 0, 1, 0, 0);
    wr(16'h080F);
    chk("post_rst_fill16", 0, 1, 0, 0, 0);
    do_flip();
    set_q_seq(16'h0800);
    chk("post_rst_flip", 1, 0, 1, 1, 0);

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    tick();
    vectors = vectors + 1;
    if (sb.size() > 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    vectors = vectors + 1;
    if (fd_seen != 5) begin
      miscompares = miscompares + 1;
      $display("FAIL flip_done_count: got %0d, want 5", fd_seen);
    end
    vectors = vectors + 1;
    if (fe_seen != 2) begin
      miscompares = miscompares + 1;
      $display("FAIL flip_err_count: got %0d, want 2", fe_seen);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
